// File: rtl/sound_pkg.sv
// Shared types and ROM helpers for the tone sequencer: note ids, half-period
// table, per-effect melody ROM and the sequencer state encoding.
package sound_pkg;

  localparam int unsigned HALF_W = 17;

  typedef enum logic [2:0] {END, C4, G4, A4, C5, E5, G5, C6} note_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Half-period in clocks at 50 MHz; END maps to 0 (silent).
  function automatic logic [HALF_W-1:0] note_half_period(input note_t n);
    logic [HALF_W-1:0] hp;
    case (n)
      C4:      hp = 17'd95556;
      G4:      hp = 17'd63776;
      A4:      hp = 17'd56818;
      C5:      hp = 17'd47778;
      E5:      hp = 17'd37921;
      G5:      hp = 17'd31888;
      C6:      hp = 17'd23889;
      default: hp = 17'd0;
    endcase
    return hp;
  endfunction

  // Melody ROM indexed by effect id and note index; unused slots read END.
  function automatic note_t melody_note(input logic [3:0] tone, input logic [1:0] idx);
    note_t n;
    case ({tone, idx})
      {4'd1, 2'd0}: n = G4;
      {4'd1, 2'd1}: n = C4;
      {4'd2, 2'd0}: n = C5;
      {4'd2, 2'd1}: n = E5;
      {4'd2, 2'd2}: n = G5;
      {4'd2, 2'd3}: n = C6;
      {4'd3, 2'd0}: n = C5;
      {4'd3, 2'd1}: n = A4;
      {4'd3, 2'd2}: n = G4;
      {4'd3, 2'd3}: n = C4;
      {4'd4, 2'd0}: n = E5;
      {4'd4, 2'd1}: n = G5;
      {4'd5, 2'd0}: n = G5;
      {4'd5, 2'd1}: n = C6;
      {4'd6, 2'd0}: n = C6;
      default:      n = END;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/square_wave_gen.sv
// Square wave generator: toggles the output every half_period clocks, held
// at zero (count and wave) while clear is asserted or run is low.
module square_wave_gen
  import sound_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              clear,
  input  logic              run,
  input  logic [HALF_W-1:0] half_period,
  output logic              wave
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q + HALF_W'(1);
    wave_d = wave_q;
    if (clear || !run || half_period == '0) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q == half_period - HALF_W'(1)) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: turns sound-controller requests into up-to-four-note
// melodies with fixed note/gap durations, driving a square wave and its half-period.
module tone_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned NOTE_MS     = 120,
  parameter int unsigned GAP_MS      = 20
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable_in,
  input  logic [3:0]  tone,
  output logic        square_out,
  output logic [16:0] note_div,
  output logic        sound_on,
  output logic        busy
);

  localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int unsigned MW = 8;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        mel_q, mel_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [MW-1:0]     ms_q, ms_d;
  logic              en_prev_q;
  logic [3:0]        tone_prev_q;
  logic [HALF_W-1:0] note_div_q, note_div_d;
  logic              sound_on_q, sound_on_d;
  logic              busy_q, busy_d;

  logic trig_c, tick_c, entry_c, tone_ok_c, note_end_c, gap_end_c;

  // New request: valid id on a rising enable or a changed id.
  assign tone_ok_c  = (tone >= 4'd1) && (tone <= 4'd6);
  assign trig_c     = enable_in && tone_ok_c && (!en_prev_q || (tone != tone_prev_q));
  assign tick_c     = (presc_q == PW'(CLKS_PER_MS - 1));
  assign note_end_c = tick_c && (ms_q == MW'(NOTE_MS - 1));
  assign gap_end_c  = tick_c && (ms_q == MW'(GAP_MS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mel_d   = mel_q;
    presc_d = '0;
    ms_d    = '0;
    entry_c = 1'b0;
    if (trig_c) begin
      state_d = PLAY;
      idx_d   = 2'd0;
      mel_d   = tone;
      entry_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: idx_d = 2'd0;
        PLAY: begin
          if (!enable_in) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end else if (note_end_c) begin
            state_d = GAP;
          end else begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            ms_d    = tick_c ? ms_q + MW'(1) : ms_q;
          end
        end
        GAP: begin
          if (!enable_in) begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end else if (gap_end_c) begin
            if (idx_q == 2'd3 || melody_note(mel_q, idx_q + 2'd1) == END) begin
              state_d = IDLE;
              idx_d   = 2'd0;
            end else begin
              state_d = PLAY;
              idx_d   = idx_q + 2'd1;
              entry_c = 1'b1;
            end
          end else begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            ms_d    = tick_c ? ms_q + MW'(1) : ms_q;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end

    sound_on_d = (state_d == PLAY);
    busy_d     = (state_d != IDLE);
    note_div_d = (state_d == PLAY) ? note_half_period(melody_note(mel_d, idx_d)) : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mel_q       <= '0;
      presc_q     <= '0;
      ms_q        <= '0;
      en_prev_q   <= 1'b0;
      tone_prev_q <= '0;
      note_div_q  <= '0;
      sound_on_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mel_q       <= mel_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      en_prev_q   <= enable_in;
      tone_prev_q <= tone;
      note_div_q  <= note_div_d;
      sound_on_q  <= sound_on_d;
      busy_q      <= busy_d;
    end
  end

  // Driven from next-state values so the wave restarts at 0 on each PLAY entry.
  square_wave_gen u_wave (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (entry_c),
    .run         (state_d == PLAY),
    .half_period (note_div_d),
    .wave        (square_out)
  );

  assign note_div = note_div_q;
  assign sound_on = sound_on_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with shortened timing (10 clk/ms, 3 ms
// notes, 1 ms gaps) plus a stand-alone square_wave_gen with a 4-clock half-period.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable_in;
  logic [3:0]  tone;
  logic        square_out;
  logic [16:0] note_div;
  logic        sound_on;
  logic        busy;

  logic        sw_clear, sw_run, sw_wave;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.CLKS_PER_MS(10), .NOTE_MS(3), .GAP_MS(1)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .enable_in  (enable_in),
    .tone       (tone),
    .square_out (square_out),
    .note_div   (note_div),
    .sound_on   (sound_on),
    .busy       (busy)
  );

  square_wave_gen u_sw (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (sw_clear),
    .run         (sw_run),
    .half_period (17'd4),
    .wave        (sw_wave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_silent(input string tag);
    check({tag, ".sound_on"}, 32'(sound_on), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".note_div"}, 32'(note_div), 32'd0);
    check({tag, ".square"}, 32'(square_out), 32'd0);
  endtask

  logic [31:0] mel2 [4];

  initial begin
    mel2[0] = 32'd47778; mel2[1] = 32'd37921; mel2[2] = 32'd31888; mel2[3] = 32'd23889;
    resetN = 1'b0; enable_in = 1'b0; tone = 4'd0; sw_clear = 1'b0; sw_run = 1'b0;
    tick(2);
    check_silent("reset");
    resetN = 1'b1;
    tick(1);

    // Effect 6: single C6 note then gap then idle
    enable_in = 1'b1; tone = 4'd6;
    tick(1);
    check("t6.note_div", 32'(note_div), 32'd23889);
    check("t6.sound_on", 32'(sound_on), 32'd1);
    check("t6.busy", 32'(busy), 32'd1);
    check("t6.square_start", 32'(square_out), 32'd0);
    tick(29);
    check("t6.last_play", 32'(sound_on), 32'd1);
    tick(1);
    check("t6.gap_sound", 32'(sound_on), 32'd0);
    check("t6.gap_busy", 32'(busy), 32'd1);
    check("t6.gap_div", 32'(note_div), 32'd0);
    tick(9);
    check("t6.gap_last", 32'(busy), 32'd1);
    tick(1);
    check("t6.idle", 32'(busy), 32'd0);
    tick(5);
    check("t6.no_retrigger", 32'(busy), 32'd0);

    // Effect 2: four notes, enable held, tone change triggers
    tone = 4'd2;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2.n%0d.first", i), 32'(note_div), mel2[i]);
      tick(29);
      check($sformatf("t2.n%0d.last", i), 32'(note_div), mel2[i]);
      tick(1);
      check($sformatf("t2.n%0d.gap", i), 32'(sound_on), 32'd0);
      tick(10);
    end
    check("t2.idle", 32'(busy), 32'd0);

    // Restart 2, switch to 4 mid second note
    enable_in = 1'b0; tick(1);
    enable_in = 1'b1; tone = 4'd2; tick(1);
    check("sw.c5", 32'(note_div), 32'd47778);
    tick(50);
    check("sw.mid_e5", 32'(note_div), 32'd37921);
    tone = 4'd4; tick(1);
    check("sw.e5", 32'(note_div), 32'd37921);
    tick(29);
    check("sw.full_dur", 32'(sound_on), 32'd1);
    tick(1);
    check("sw.gap", 32'(sound_on), 32'd0);
    tick(10);
    check("sw.g5", 32'(note_div), 32'd31888);
    tick(40);
    check("sw.end", 32'(busy), 32'd0);

    // Abort on enable drop during PLAY
    enable_in = 1'b0; tick(1);
    enable_in = 1'b1; tone = 4'd3; tick(1);
    check("ab.c5", 32'(note_div), 32'd47778);
    tick(5);
    enable_in = 1'b0; tick(1);
    check_silent("abort");

    // Invalid ids produce nothing
    enable_in = 1'b1; tone = 4'd0; tick(3);
    check("inv0.busy", 32'(busy), 32'd0);
    tone = 4'd9; tick(3);
    check("inv9.busy", 32'(busy), 32'd0);

    // Invalid id mid-melody does not abort
    tone = 4'd5; tick(1);
    check("t5.g5", 32'(note_div), 32'd31888);
    tone = 4'd9; tick(1);
    check("t5.inv_keep_on", 32'(sound_on), 32'd1);
    check("t5.inv_keep_div", 32'(note_div), 32'd31888);
    tick(31);
    check("t5.gap_busy", 32'(busy), 32'd1);
    check("t5.gap_sound", 32'(sound_on), 32'd0);

    // Async reset mid-GAP, then melody 1 right after release
    resetN = 1'b0; #1;
    check_silent("rst_gap");
    tone = 4'd1; enable_in = 1'b1;
    tick(1);
    resetN = 1'b1;
    tick(1);
    check("t1.g4", 32'(note_div), 32'd63776);
    tick(40);
    check("t1.c4", 32'(note_div), 32'd95556);
    tick(40);
    check("t1.end", 32'(busy), 32'd0);

    // Square wave with half-period 4: first rise 4 clocks after clear
    sw_clear = 1'b1; sw_run = 1'b1; tick(1);
    check("sq.clear", 32'(sw_wave), 32'd0);
    sw_clear = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      check($sformatf("sq.c%0d", j), 32'(sw_wave), 32'((j / 4) % 2));
    end
    sw_run = 1'b0; tick(1);
    check("sq.stop", 32'(sw_wave), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

- Sits directly downstream of the sound controller: consumes its `enable_out` / `tone[3:0]` pair.
- Turns each sound request into a short melody of up to four notes, with fixed note and gap durations.
- Drives a 1-bit square wave plus the current half-period value to the audio output stage.
- Handles per-effect sequencing, restart on a new request, and silence between notes.

## Interface
Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick (50 MHz clock)
- NOTE_MS, 120, audible duration of each note in ms
- GAP_MS, 20, silent gap after each note in ms

Ports:
- clk  input  1  system clock; one clock domain
- resetN  input  1  asynchronous active-low reset
- enable_in  input  1  sound request enable (sound controller `enable_out`)
- tone  input  4  effect id; 1..6 valid, 0 and 7..15 mean silence
- square_out  output  1  audio square wave; 0 whenever not sounding
- note_div  output  17  half-period of the current note, in clocks; 0 when silent
- sound_on  output  1  high while a note is audible (PLAY state)
- busy  output  1  high in PLAY or GAP

## Operation
- FSM states: IDLE, PLAY, GAP.
- Trigger condition, sampled each clk:
  - enable_in=1, tone in 1..6, and
  - either enable_in was 0 last cycle, or tone differs from last cycle's value.
- A trigger in any state does the following:
  - note index := 0 and state := PLAY;
  - the ms prescaler and duration counter are cleared;
  - the melody id is latched from tone. Any playing melody is aborted and restarted.
- enable_in=0 in PLAY or GAP aborts to IDLE; all outputs are silent on the next cycle.
- tone changing to an invalid id while enable_in=1 does not abort the melody and does not trigger.
- PLAY:
  - note_div = the table value for the current note; square_out toggles every note_div clocks.
  - After NOTE_MS ticks the FSM moves to GAP.
- GAP:
  - Output is silent.
  - After GAP_MS ticks:
    - if the note index is 3, or the next ROM entry is END, go to IDLE;
    - otherwise increment the note index and go to PLAY.
- Melody ROM (note sequences):
  - 1: G4, C4, END
  - 2: C5, E5, G5, C6
  - 3: C5, A4, G4, C4
  - 4: E5, G5, END
  - 5: G5, C6, END
  - 6: C6, END
- Half-period table in clocks (50 MHz):
  - C4 = 95556, G4 = 63776, A4 = 56818
  - C5 = 47778, E5 = 37921, G5 = 31888, C6 = 23889

## Timing
- Reset values: state=IDLE, square_out=0, note_div=0, sound_on=0, busy=0, note index=0, all counters 0, history registers (previous enable_in, previous tone) 0.
- Latency: a trigger sampled at edge k shows sound_on=1, busy=1 and note_div loaded after edge k.
- First square_out rise: exactly note_div clocks after PLAY entry. The half-period counter is cleared on every PLAY entry, so square_out starts at 0 for each note.
- Durations: PLAY lasts exactly NOTE_MS*CLKS_PER_MS cycles and GAP lasts exactly GAP_MS*CLKS_PER_MS cycles. The prescaler is cleared on every state entry.
- Simultaneous events:
  - trigger wins over the end of a duration and over the GAP→IDLE transition;
  - abort (enable_in=0) wins over a duration end.
- Full melody cost is 4*(NOTE_MS+GAP_MS)=560 ms, which is shorter than the upstream 2 s enable window.
- Counter widths:
  - prescaler: ceil(log2(CLKS_PER_MS)) bits;
  - ms counter: 8 bits; NOTE_MS and GAP_MS must be ≤255;
  - half-period counter: 17 bits.
- Reset mid-melody: everything returns to the reset values asynchronously. No trigger is generated on the first cycle after reset unless enable_in=1 with a valid tone, because the history registers are 0.

## Structure
- Package `sound_pkg` holds:
  - note_t enum {END, C4, G4, A4, C5, E5, G5, C6};
  - constant function note_half_period(note_t) returning 17 bits;
  - constant function melody_note(tone[3:0], idx[1:0]) returning note_t;
  - state enum {IDLE, PLAY, GAP}.
- Sub-module `square_wave_gen`:
  - inputs: clk, resetN, clear, run, half_period[16:0];
  - output: wave;
  - counts to half_period-1, then toggles; the count is held at 0 while clear or !run.
- The top level contains the FSM, the ms prescaler, the duration counter and the trigger detector.

## Test plan
All scenarios use CLKS_PER_MS=10, NOTE_MS=3, GAP_MS=1.
- Reset → all outputs 0. Raise enable_in with tone=6 → next cycle note_div=23889, sound_on=1. After 30 cycles GAP with silent outputs; after 10 more, IDLE with busy=0.
- tone=2 held → note_div sequence 47778, 37921, 31888, 23889, each for 30 cycles, separated by 10-cycle gaps; IDLE after 160 cycles.
- Square wave: force the table entry for C6 to half-period 4 (test override) → square_out period 8, first rise 4 cycles after PLAY entry.
- Change tone 2→4 mid-second-note → next cycle note_div=37921 (E5, first note of melody 4) with full 30-cycle duration; the melody ends after E5, G5.
- Drop enable_in during PLAY → next cycle sound_on=0, square_out=0, busy=0. tone=0 or 9 with enable_in=1 → no activity.
- Assert resetN=0 mid-GAP → immediate reset values. Release with enable_in=1, tone=1 → melody 1 starts (note_div=63776).
